// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing source with registered {dout, hs, vs, de}.
//
// Counts pixels (h_cnt) and lines (v_cnt) on each ce_pix-enabled clk edge and
// registers sync, data-enable, pixel data and a start-of-frame pulse that were
// computed from the counter state before that edge (one ce_pix pipeline stage).
//
// Optional feature macro: VTG_PATTERN_EN
//   defined   -> built-in test-pattern generator drives dout; din is ignored
//   undefined -> dout registers din in the active region; pattern is ignored
//
// Ports:
//   clk      in   1  sole clock
//   reset_n  in   1  synchronous active-low reset
//   ce_pix   in   1  pixel clock enable
//   pattern  in   2  test-pattern select (VTG_PATTERN_EN only)
//   din      in  24  external RGB {r,g,b} (without VTG_PATTERN_EN)
//   x        out 12  current horizontal counter (combinational)
//   y        out 12  current vertical counter (combinational)
//   dout     out 24  registered RGB {r,g,b}
//   hs_out   out  1  registered horizontal sync
//   vs_out   out  1  registered vertical sync
//   de_out   out  1  registered data enable
//   sof      out  1  one-clk pulse with the first active pixel of a frame
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce_pix,
  input  logic [1:0]  pattern,
  input  logic [23:0] din,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic [23:0] dout,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        sof
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_SS     = H_ACTIVE + H_FP;
  localparam int H_SE     = H_ACTIVE + H_FP + H_SYNC;
  localparam int V_SS     = V_ACTIVE + V_FP;
  localparam int V_SE     = V_ACTIVE + V_FP + V_SYNC;
  localparam logic HS_P   = 1'(HS_POL);
  localparam logic VS_P   = 1'(VS_POL);

  logic [11:0] h_cnt_r;
  logic [11:0] v_cnt_r;
  logic        active_s;
  logic        hs_act_s;
  logic        vs_act_s;
  logic        first_s;
  logic        last_h_s;
  logic        last_v_s;
  logic [23:0] pix_s;

  assign x = h_cnt_r;
  assign y = v_cnt_r;

  // Comparisons are done at 13 bits so a 4096 total cannot alias to 0.
  assign active_s = ({1'b0, h_cnt_r} < 13'(H_ACTIVE)) && ({1'b0, v_cnt_r} < 13'(V_ACTIVE));
  assign hs_act_s = ({1'b0, h_cnt_r} >= 13'(H_SS)) && ({1'b0, h_cnt_r} < 13'(H_SE));
  assign vs_act_s = ({1'b0, v_cnt_r} >= 13'(V_SS)) && ({1'b0, v_cnt_r} < 13'(V_SE));
  assign first_s  = (h_cnt_r == 12'd0) && (v_cnt_r == 12'd0);
  assign last_h_s = ({1'b0, h_cnt_r} == 13'(H_TOTAL - 1));
  assign last_v_s = ({1'b0, v_cnt_r} == 13'(V_TOTAL - 1));

`ifdef VTG_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [1:0] pat_r;
  logic [1:0] pat_sel_s;
  logic       unused_din;

  assign unused_din = ^din;

  // Colour-bar lookup: the last bar absorbs any remainder of H_ACTIVE/8.
  function automatic logic [23:0] bar_colour(input logic [11:0] h);
    logic [2:0]  idx;
    logic [23:0] col;
    idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if ({1'b0, h} >= 13'(i * BAR_W)) begin
        idx = 3'(i);
      end
    end
    case (idx)
      3'd0:    col = 24'hFFFFFF;
      3'd1:    col = 24'hFFFF00;
      3'd2:    col = 24'h00FFFF;
      3'd3:    col = 24'h00FF00;
      3'd4:    col = 24'hFF00FF;
      3'd5:    col = 24'hFF0000;
      3'd6:    col = 24'h0000FF;
      default: col = 24'h000000;
    endcase
    return col;
  endfunction

  // Pixel (0,0) already uses the newly selected pattern so a frame is uniform.
  always_comb begin
    pat_sel_s = pat_r;
    if (first_s) begin
      pat_sel_s = pattern;
    end else begin
      pat_sel_s = pat_r;
    end
  end

  // Test-pattern pixel generator, blanked outside the active region.
  always_comb begin
    pix_s = 24'h000000;
    if (active_s) begin
      case (pat_sel_s)
        2'd0:    pix_s = bar_colour(h_cnt_r);
        2'd1:    pix_s = {3{h_cnt_r[7:0]}};
        2'd2:    pix_s = {3{v_cnt_r[7:0]}};
        2'd3:    pix_s = (h_cnt_r[3] ^ v_cnt_r[3]) ? 24'hFFFFFF : 24'h000000;
        default: pix_s = 24'h000000;
      endcase
    end else begin
      pix_s = 24'h000000;
    end
  end

  // Pattern latch, updated only at the start of a frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat_r <= 2'd0;
    end else if (ce_pix && first_s) begin
      pat_r <= pattern;
    end else begin
      pat_r <= pat_r;
    end
  end
`else
  logic unused_pattern;

  assign unused_pattern = ^pattern;

  // External pixel path, blanked outside the active region.
  always_comb begin
    pix_s = 24'h000000;
    if (active_s) begin
      pix_s = din;
    end else begin
      pix_s = 24'h000000;
    end
  end
`endif

  // Raster counters and registered outputs; sof is a single-clk pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_cnt_r <= 12'd0;
      v_cnt_r <= 12'd0;
      dout    <= 24'h000000;
      de_out  <= 1'b0;
      hs_out  <= ~HS_P;
      vs_out  <= ~VS_P;
      sof     <= 1'b0;
    end else if (ce_pix) begin
      if (last_h_s) begin
        h_cnt_r <= 12'd0;
        if (last_v_s) begin
          v_cnt_r <= 12'd0;
        end else begin
          v_cnt_r <= v_cnt_r + 12'd1;
        end
      end else begin
        h_cnt_r <= h_cnt_r + 12'd1;
        v_cnt_r <= v_cnt_r;
      end
      dout   <= pix_s;
      de_out <= active_s;
      hs_out <= hs_act_s ~^ HS_P;
      vs_out <= vs_act_s ~^ VS_P;
      sof    <= first_s;
    end else begin
      sof <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed self-checking bench for video_timing_gen using a small raster:
// H 16/2/3/3 (24 pixels/line), V 4/1/2/1 (8 lines/frame), HS_POL=0, VS_POL=1.
module tb_video_timing_gen;

  logic        clk;
  logic        reset_n;
  logic        ce_pix;
  logic [1:0]  pattern;
  logic [23:0] din;
  logic [11:0] x;
  logic [11:0] y;
  logic [23:0] dout;
  logic        hs_out;
  logic        vs_out;
  logic        de_out;
  logic        sof;

  int total = 0;
  int bad   = 0;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4),  .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0),    .VS_POL(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .pattern(pattern), .din(din),
    .x(x), .y(y), .dout(dout), .hs_out(hs_out), .vs_out(vs_out), .de_out(de_out), .sof(sof)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hold reset for two edges and release it so the next posedge is pixel 0.
  task automatic do_reset();
    reset_n = 1'b0;
    ce_pix  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (30) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (hs_out !== 1'b1) begin bad++; $display("FAIL rst_hs: got %b want 1", hs_out); end
    total++; if (vs_out !== 1'b0) begin bad++; $display("FAIL rst_vs: got %b want 0", vs_out); end
    total++; if (de_out !== 1'b0) begin bad++; $display("FAIL rst_de: got %b want 0", de_out); end
    total++; if (dout !== 24'h0) begin bad++; $display("FAIL rst_dout: got %h want 000000", dout); end
    total++; if (sof !== 1'b0) begin bad++; $display("FAIL rst_sof: got %b want 0", sof); end
    total++; if (x !== 12'd0 || y !== 12'd0) begin bad++; $display("FAIL rst_xy: got %0d,%0d want 0,0", x, y); end
    @(negedge clk);
    reset_n = 1'b1;
    ce_pix  = 1'b1;
    @(posedge clk); #1;
    total++; if (de_out !== 1'b1) begin bad++; $display("FAIL rel_de: got %b want 1", de_out); end
    total++; if (sof !== 1'b1) begin bad++; $display("FAIL rel_sof: got %b want 1", sof); end
    total++; if (x !== 12'd1 || y !== 12'd0) begin bad++; $display("FAIL rel_xy: got %0d,%0d want 1,0", x, y); end
    @(posedge clk); #1;
    total++; if (sof !== 1'b0) begin bad++; $display("FAIL rel_sof_w: got %b want 0", sof); end
  endtask

  task automatic test_line();
    int de_cnt;
    logic exp_de, exp_hs;
    de_cnt = 0;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      exp_de = (k < 16);
      exp_hs = !(k >= 18 && k <= 20);
      if (de_out === 1'b1) de_cnt++;
      total++; if (de_out !== exp_de) begin bad++; $display("FAIL line_de x=%0d: got %b want %b", k, de_out, exp_de); end
      total++; if (hs_out !== exp_hs) begin bad++; $display("FAIL line_hs x=%0d: got %b want %b", k, hs_out, exp_hs); end
    end
    total++; if (de_cnt != 16) begin bad++; $display("FAIL line_de_cnt: got %0d want 16", de_cnt); end
  endtask

  task automatic test_frame();
    int vs_cnt, rise_at, sof_cnt, sof2_at;
    logic prev_vs;
    vs_cnt = 0; rise_at = -1; sof_cnt = 0; sof2_at = -1; prev_vs = 1'b0;
    do_reset();
    for (int k = 0; k < 384; k++) begin
      @(posedge clk); #1;
      if (k < 192 && vs_out === 1'b1) vs_cnt++;
      if (rise_at < 0 && vs_out === 1'b1 && prev_vs === 1'b0) rise_at = k;
      prev_vs = vs_out;
      if (sof === 1'b1) begin
        sof_cnt++;
        if (k > 0 && sof2_at < 0) sof2_at = k;
      end
    end
    total++; if (vs_cnt != 48) begin bad++; $display("FAIL frame_vs_cnt: got %0d want 48", vs_cnt); end
    total++; if (rise_at != 120) begin bad++; $display("FAIL frame_vs_rise: got %0d want 120", rise_at); end
    total++; if (sof_cnt != 2) begin bad++; $display("FAIL frame_sof_cnt: got %0d want 2", sof_cnt); end
    total++; if (sof2_at != 192) begin bad++; $display("FAIL frame_sof_period: got %0d want 192", sof2_at); end
  endtask

  task automatic test_ce_gated();
    int rises[$];
    int sof_cnt;
    logic p_de, p_hs, p_vs;
    logic [23:0] p_dout;
    sof_cnt = 0;
    do_reset();
    p_de = 1'b0; p_hs = 1'b1; p_vs = 1'b0; p_dout = 24'h0;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if ((c % 3) != 0) begin
        total++;
        if (de_out !== p_de || hs_out !== p_hs || vs_out !== p_vs || dout !== p_dout || sof !== 1'b0) begin
          bad++;
          $display("FAIL ce_hold c=%0d: got de%b hs%b vs%b d%h sof%b want de%b hs%b vs%b d%h sof0",
                   c, de_out, hs_out, vs_out, dout, sof, p_de, p_hs, p_vs, p_dout);
        end
      end
      if (de_out === 1'b1 && p_de === 1'b0) rises.push_back(c);
      if (sof === 1'b1) sof_cnt++;
      p_de = de_out; p_hs = hs_out; p_vs = vs_out; p_dout = dout;
      ce_pix = (((c + 1) % 3) == 0);
    end
    ce_pix = 1'b1;
    total++;
    if (rises.size() < 3) begin
      bad++; $display("FAIL ce_rises: got %0d want >=3", rises.size());
    end else begin
      if (rises[0] != 0 || rises[1] - rises[0] != 72 || rises[2] - rises[1] != 72) begin
        bad++; $display("FAIL ce_line_period: got %0d,%0d,%0d want 0,72,144", rises[0], rises[1], rises[2]);
      end
    end
    total++; if (sof_cnt != 2) begin bad++; $display("FAIL ce_sof_cnt: got %0d want 2", sof_cnt); end
  endtask

`ifdef VTG_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] exp;
    logic chk;
    pattern = 2'd0;
    din = 24'h0;
    do_reset();
    for (int k = 0; k < 420; k++) begin
      @(posedge clk); #1;
      chk = 1'b1;
      case (k)
        0, 1:    exp = 24'hFFFFFF;
        2, 3:    exp = 24'hFFFF00;
        4:       exp = 24'h00FFFF;
        14, 15:  exp = 24'h000000;
        48:      exp = 24'hFFFFFF;
        50:      exp = 24'hFFFF00;
        58:      exp = 24'hFF0000;
        196:     exp = 24'h000000;
        200:     exp = 24'hFFFFFF;
        208:     exp = 24'h000000;
        224:     exp = 24'hFFFFFF;
        320:     exp = 24'h000000;
        389:     exp = 24'h050505;
        417:     exp = 24'h090909;
        default: begin exp = 24'h0; chk = 1'b0; end
      endcase
      if (chk) begin
        total++;
        if (dout !== exp) begin bad++; $display("FAIL pattern k=%0d: got %h want %h", k, dout, exp); end
      end
      if (k == 30) pattern = 2'd3;
      if (k == 383) pattern = 2'd1;
    end
  endtask
`else
  task automatic test_din();
    logic [23:0] exp;
    int ln, px;
    pattern = 2'd0;
    din = 24'hA5C3E1;
    do_reset();
    for (int k = 0; k < 192; k++) begin
      @(posedge clk); #1;
      px = k % 24;
      ln = k / 24;
      if (px < 16 && ln < 4) exp = (k > 40) ? 24'h123456 : 24'hA5C3E1;
      else exp = 24'h000000;
      total++;
      if (dout !== exp) begin bad++; $display("FAIL din k=%0d: got %h want %h", k, dout, exp); end
      if (k == 40) din = 24'h123456;
    end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    ce_pix  = 1'b1;
    pattern = 2'd0;
    din     = 24'h0;
    test_reset();
    test_line();
    test_frame();
    test_ce_gated();
`ifdef VTG_PATTERN_EN
    test_pattern();
`else
    test_din();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
